elastic_buffer: RTL and testbench

ELASTIC_BUFFER -- requirements
Module: elastic_buffer

---
 rtl/pipe_pkg.sv | 11 +
 rtl/elastic_mem.sv | 25 ++
 rtl/elastic_buffer.sv | 104 ++++++++++
 tb/tb_elastic_buffer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline defaults and sizing helpers.
// Used by the elastic buffer and its storage.
package pipe_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_mem.sv
// Unreset storage array for the elastic buffer.
// One synchronous write port, one asynchronous read port.
module elastic_mem
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/elastic_buffer.sv
// Elastic buffer with registered head, ready and flags.
// The head register mirrors the oldest stored entry.
module elastic_buffer
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        flush,
  output logic [cnt_w(DEPTH)-1:0]     count,
  output logic                        almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [AW-1:0]         rptr;
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic [CW-1:0]         count_n;
  logic [DATA_WIDTH-1:0] head_n;
  logic                  vld_n;
  logic                  push;
  logic                  pop;

  assign push  = in_valid && in_ready;
  assign pop   = out_valid && out_ready;
  assign raddr = rptr + 1'b1;

  elastic_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wptr),
    .wdata (in_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    count_n = count;
    if (flush)             count_n = '0;
    else if (push && !pop) count_n = count + ONE;
    else if (pop && !push) count_n = count - ONE;
  end

  // Next head: entry behind the popped one, or the word being pushed
  // when that entry is not yet in storage.
  always_comb begin
    head_n = out_data;
    vld_n  = out_valid;
    if (count_n == '0) begin
      vld_n  = 1'b0;
      head_n = '0;
    end else if (pop) begin
      vld_n  = 1'b1;
      head_n = (count == ONE) ? in_data : rdata;
    end else if (!out_valid) begin
      vld_n  = 1'b1;
      head_n = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      in_ready    <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      count       <= count_n;
      out_valid   <= vld_n;
      out_data    <= head_n;
      in_ready    <= (count_n != FULL);
      almost_full <= (count_n >= AFULL);
      if (flush) begin
        rptr <= '0;
        wptr <= '0;
      end else begin
        if (pop)  rptr <= rptr + 1'b1;
        if (push) wptr <= wptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_elastic_buffer.sv
// Self-checking bench for elastic_buffer against a queue model.
// Directed scenarios first, then randomized traffic.
module tb_elastic_buffer;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int AF = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    count;
  logic          almost_full;

  elastic_buffer #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DP),
    .AFULL_LEVEL (AF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] popped[$];
  logic          ir_m = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("out_valid", int'(out_valid), int'(q.size() != 0));
    if (q.size() != 0) chk("out_data", int'(out_data), int'(q[0]));
    chk("count", int'(count), q.size());
    chk("almost_full", int'(almost_full), int'(q.size() >= AF));
    chk("in_ready", int'(in_ready), int'(ir_m));
  endtask

  // Drive one cycle starting from a negedge; model advances at the edge.
  task automatic step(input logic iv, input logic [DW-1:0] d,
                      input logic ordy, input logic fl);
    logic push_m;
    logic pop_m;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    push_m = iv && ir_m;
    pop_m  = ordy && (q.size() != 0);
    if (out_valid && ordy) popped.push_back(out_data);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (pop_m)  void'(q.pop_front());
      if (push_m) q.push_back(d);
    end
    ir_m = (q.size() != DP);
    @(negedge clk);
    check_model();
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_data"}, int'(out_data), 0);
    chk({tag, "_ready"}, int'(in_ready), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_afull"}, int'(almost_full), 0);
  endtask

  initial begin
    int maxc;
    #1;
    reset_check("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    ir_m  = 1'b0;
    chk("ready_before_edge", int'(in_ready), 0);

    // First edge after release raises in_ready; in_valid there is refused.
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ready_rises", int'(in_ready), 1);
    chk("no_push_in_reset_gap", int'(count), 0);

    // Single word held then popped once
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_valid", int'(out_valid), 1);
    chk("a5_data", int'(out_data), 8'hA5);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("a5_hold", int'(out_data), 8'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("a5_popped", int'(popped[$]), 8'hA5);
    chk("a5_empty_valid", int'(out_valid), 0);
    chk("a5_empty_count", int'(count), 0);

    // Fill to full, then full-with-pop behaviour
    step(1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b1, 8'h21, 1'b0, 1'b0);
    chk("af_at2", int'(almost_full), 0);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    chk("af_at3", int'(almost_full), 1);
    step(1'b1, 8'h43, 1'b0, 1'b0);
    chk("full_count", int'(count), 4);
    chk("full_ready", int'(in_ready), 0);
    step(1'b1, 8'h54, 1'b0, 1'b0);
    chk("no_fifth", int'(count), 4);
    step(1'b1, 8'h54, 1'b1, 1'b0);
    chk("full_pop_data", int'(popped[$]), 8'h10);
    chk("full_pop_count", int'(count), 3);
    chk("full_pop_ready", int'(in_ready), 1);
    step(1'b1, 8'h54, 1'b0, 1'b0);
    chk("late_push_count", int'(count), 4);
    popped.delete();
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_n", popped.size(), 4);
    if (popped.size() == 4) begin
      chk("drain0", int'(popped[0]), 8'h21);
      chk("drain1", int'(popped[1]), 8'h32);
      chk("drain2", int'(popped[2]), 8'h43);
      chk("drain3", int'(popped[3]), 8'h54);
    end

    // Streaming: one transfer per cycle, occupancy stays at 1
    popped.delete();
    maxc = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0);
      if (int'(count) > maxc) maxc = int'(count);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_n", popped.size(), 16);
    chk("stream_maxc", maxc, 1);
    for (int i = 0; i < 16 && i < popped.size(); i++)
      chk("stream_order", int'(popped[i]), i);

    // Flush beats a coincident push
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    chk("flush_count", int'(count), 0);
    chk("flush_valid", int'(out_valid), 0);
    chk("flush_ready", int'(in_ready), 1);
    popped.delete();
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_no77", popped.size(), 0);

    // Asynchronous reset with two words held
    step(1'b1, 8'hB1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 reset_check("rst1");
    q.delete();
    ir_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rst1_ready", int'(in_ready), 1);
    popped.delete();
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rst1_nostale", popped.size(), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), DW'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
